multi_slope_pwm: RTL and testbench
==================================

Name: multi_slope_pwm

Overview:
- Parametrised successor to the run-up PWM generator of the multi-slope converter.
- Produces the run-up switch drive `pwm`. Each period uses either mode A, a narrow centred pulse, or mode B, a wide pulse.
- Counts completed mode-A and mode-B pulses for the residue/charge-balance arithmetic.
- New relative to the previous generation:
  - explicit IDLE/RUN state machine;
  - mode changes take effect only at period boundaries;
  - period-end strobe;
  - saturating tallies;
  - optional atomic capture.

Parameters:
- CW, 10: width of period counter `count`.
- PERIOD, 259: clocks per PWM period. Legal range 8..2^CW-1.
- EDGE, 2: mode-B rise position; mode-B fall is PERIOD-EDGE. Requires 1 <= EDGE < PERIOD/2-1.
- HALF, 2: mode-A half-width around the centre PERIOD>>1. Requires 1 <= HALF < (PERIOD>>1)-1.
- TW, 32: width of tally counters.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: one-cycle pulse; clear tallies and enter/restart RUN.
- stop, input, 1: one-cycle pulse; return to IDLE.
- enable, input, 1: level; in RUN, low holds the period at its origin.
- reload, input, 1: one-cycle pulse; restart the current period from count 0.
- mode_req, input, 1: 0 = mode A, 1 = mode B. Sampled only at period boundaries.
- pwm, output, 1: switch drive.
- pwm_mode, output, 1: mode of the period in progress.
- period_end, output, 1: one-cycle strobe on the last count of each period.
- running, output, 1: high in RUN.
- mode_a_cnt, output, TW: completed mode-A pulses, saturating.
- mode_b_cnt, output, TW: completed mode-B pulses, saturating.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, count=0, pwm=0, pwm_mode=0, period_end=0, running=0, both tallies=0.
- Priority each edge: start > stop > reload > enable low > normal counting.
- IDLE state:
  - count=0, pwm=0, period_end=0.
  - pwm_mode tracks mode_req every cycle.
  - Tallies hold.
- IDLE to RUN on start:
  - Tallies cleared; count=0; pwm_mode<=mode_req.
  - The first RUN cycle sees count=0.
- start while in RUN: identical restart; tallies cleared.
- stop in RUN: next state IDLE; pwm<=0, count<=0; tallies hold. stop in IDLE is ignored.
- RUN with enable=1:
  - count increments by 1 each cycle and wraps PERIOD-1 to 0.
  - period_end=1 exactly during the cycle in which count==PERIOD-1 (registered, decoded from the next count).
  - On the wrap edge, pwm_mode<=mode_req.
- Edge positions:
  - Mode A: rise RA=(PERIOD>>1)-HALF, fall FA=(PERIOD>>1)+HALF.
  - Mode B: rise RB=EDGE, fall FB=PERIOD-EDGE.
- pwm is registered:
  - On the edge where count==rise, pwm<=1.
  - On the edge where count==fall, pwm<=0.
  - High width = fall-rise cycles. Defaults: mode A 4 cycles (127 to 131), mode B 255 cycles (2 to 257).
- Tally update: on the edge where count==fall, the tally for pwm_mode increments, in the same edge as pwm falls. At 2^TW-1 it holds (saturates).
- RUN with enable=0: count<=0, pwm<=0, pwm_mode<=mode_req, period_end=0. A partial period is not tallied.
- reload in RUN:
  - Same as enable=0 for one cycle: count<=0, pwm<=0, pwm_mode<=mode_req.
  - The aborted period is not tallied.
  - reload in IDLE is ignored.
- mode_req changes mid-period have no effect until the next wrap, reload, enable-low or start.
- Simultaneous start and stop: start wins. Simultaneous reload and count==fall: reload wins, no tally.
- Width rules:
  - count comparisons are CW-bit unsigned.
  - Edge constants are computed at elaboration.
  - A parameter violation is a generate-time error (`$error` in an initial/generate check).

Optional Feature:
- Macro: MULTI_SLOPE_PWM_CAPTURE_EN.
- When defined, adds the following ports:
  - `capture` input 1;
  - `cap_a` output TW;
  - `cap_b` output TW;
  - `cap_valid` output 1.
- On the edge sampling capture=1:
  - cap_a and cap_b are loaded atomically with the tally next-state values, including any coinciding increment or start-clear.
  - cap_valid pulses high for one cycle.
  - All three reset to 0.
- When not defined: the ports are absent, with no logic and no behavioural change.

Test Plan:
- Reset then start with mode_req=0, enable=1, defaults:
  - pwm high for exactly 4 cycles, count 127 to 131;
  - period_end every 259 clocks;
  - mode_a_cnt=3 after 3 periods; mode_b_cnt=0.
- Mode switch: mode_req changes 0 to 1 at count=50.
  - The current period stays mode A with a 4-cycle pulse.
  - The next period is mode B, with pwm high 255 cycles starting at count 2.
  - pwm_mode changes on the wrap edge.
- Abort: reload asserted at count=200 in mode B.
  - pwm drops the next cycle; mode_b_cnt is unchanged.
  - The new period starts at count 0.
  - enable low for 10 cycles behaves the same, with pwm=0 throughout.
- Control: start and stop pulsed in the same cycle during RUN.
  - Restart; tallies go to 0.
  - A later lone stop sets running to 0 and pwm to 0; tallies hold.
- Saturation: TW=4, mode B, run 20 periods.
  - mode_b_cnt reaches 15 and stays 15.
- Async reset asserted mid-pulse between clock edges:
  - pwm, tallies and running clear immediately;
  - there is no activity after deassertion until start.
- With MULTI_SLOPE_PWM_CAPTURE_EN defined: capture pulsed in the same cycle as a mode-A fall with mode_a_cnt=5.
  - cap_a=6, and cap_valid is high for 1 cycle.

Source files
------------

// File: rtl/multi_slope_pwm.sv
// multi_slope_pwm: run-up PWM generator for the multi-slope converter.
//
// Each PWM period is PERIOD clocks. A period runs in one of two modes:
//   mode A: a narrow pulse centred on PERIOD>>1. It rises at (PERIOD>>1)-HALF
//           and falls at (PERIOD>>1)+HALF.
//   mode B: a wide pulse. It rises at EDGE and falls at PERIOD-EDGE.
// The mode is latched only at period boundaries. Each completed pulse bumps a
// saturating per-mode tally, which the residue arithmetic uses.
//
// Optional feature (macro MULTI_SLOPE_PWM_CAPTURE_EN): adds an atomic snapshot
// of both tallies, taken on a capture pulse.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   start      in   pulse: clear tallies, enter/restart RUN
//   stop       in   pulse: return to IDLE (tallies hold)
//   enable     in   level: low in RUN parks the period at its origin
//   reload     in   pulse: restart the current period from count 0
//   mode_req   in   0 = mode A, 1 = mode B (latched at period boundaries)
//   capture    in   (optional) pulse: snapshot tallies into cap_a/cap_b
//   cap_a      out  (optional) captured mode-A tally
//   cap_b      out  (optional) captured mode-B tally
//   cap_valid  out  (optional) one-cycle strobe after a capture
//   pwm        out  switch drive (registered)
//   pwm_mode   out  mode of the period in progress
//   period_end out  strobe during the last count of each period
//   running    out  high in RUN
//   mode_a_cnt out  completed mode-A pulses, saturating
//   mode_b_cnt out  completed mode-B pulses, saturating
module multi_slope_pwm #(
  parameter int CW     = 10,
  parameter int PERIOD = 259,
  parameter int EDGE   = 2,
  parameter int HALF   = 2,
  parameter int TW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic          enable,
  input  logic          reload,
  input  logic          mode_req,
`ifdef MULTI_SLOPE_PWM_CAPTURE_EN
  input  logic          capture,
  output logic [TW-1:0] cap_a,
  output logic [TW-1:0] cap_b,
  output logic          cap_valid,
`endif
  output logic          pwm,
  output logic          pwm_mode,
  output logic          period_end,
  output logic          running,
  output logic [TW-1:0] mode_a_cnt,
  output logic [TW-1:0] mode_b_cnt
);

  // Illegal parameter sets are rejected at elaboration.
  if ((PERIOD < 8) || (PERIOD > ((1 << CW) - 1))) begin : g_bad_period
    $error("multi_slope_pwm: PERIOD out of range for CW");
  end
  if ((EDGE < 1) || (EDGE >= (PERIOD / 2) - 1)) begin : g_bad_edge
    $error("multi_slope_pwm: EDGE out of range");
  end
  if ((HALF < 1) || (HALF >= (PERIOD >> 1) - 1)) begin : g_bad_half
    $error("multi_slope_pwm: HALF out of range");
  end
  if (TW < 1) begin : g_bad_tw
    $error("multi_slope_pwm: TW must be at least 1");
  end

  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [CW-1:0] RA   = CW'((PERIOD >> 1) - HALF);
  localparam logic [CW-1:0] FA   = CW'((PERIOD >> 1) + HALF);
  localparam logic [CW-1:0] RB   = CW'(EDGE);
  localparam logic [CW-1:0] FB   = CW'(PERIOD - EDGE);
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Saturating increment for the tallies.
  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
    sat_inc = (v == TMAX) ? v : (v + TW'(1));
  endfunction

  state_t        state_r, state_s;
  logic [CW-1:0] count_r, count_s;
  logic [CW-1:0] rise_s, fall_s;
  logic          pwm_r, pwm_s;
  logic          mode_r, mode_s;
  logic          period_end_r, period_end_s;
  logic [TW-1:0] a_cnt_r, a_cnt_s;
  logic [TW-1:0] b_cnt_r, b_cnt_s;

  // Next-state logic. The branch order sets the priority:
  // start > stop > reload > enable low > normal counting.
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    pwm_s   = pwm_r;
    mode_s  = mode_r;
    a_cnt_s = a_cnt_r;
    b_cnt_s = b_cnt_r;
    rise_s  = mode_r ? RB : RA;
    fall_s  = mode_r ? FB : FA;

    if (start) begin
      state_s = RUN;
      count_s = {CW{1'b0}};
      pwm_s   = 1'b0;
      mode_s  = mode_req;
      a_cnt_s = {TW{1'b0}};
      b_cnt_s = {TW{1'b0}};
    end else if (state_r == IDLE) begin
      // IDLE parks the counter. The displayed mode follows the request.
      count_s = {CW{1'b0}};
      pwm_s   = 1'b0;
      mode_s  = mode_req;
    end else if (stop) begin
      state_s = IDLE;
      count_s = {CW{1'b0}};
      pwm_s   = 1'b0;
    end else if (reload || !enable) begin
      // Abort the period in progress. A pulse cut short here is never tallied.
      count_s = {CW{1'b0}};
      pwm_s   = 1'b0;
      mode_s  = mode_req;
    end else begin
      if (count_r == LAST) begin
        count_s = {CW{1'b0}};
        mode_s  = mode_req;
      end else begin
        count_s = count_r + CW'(1);
      end
      if (count_r == rise_s) begin
        pwm_s = 1'b1;
      end else if (count_r == fall_s) begin
        pwm_s = 1'b0;
        if (mode_r) begin
          b_cnt_s = sat_inc(b_cnt_r);
        end else begin
          a_cnt_s = sat_inc(a_cnt_r);
        end
      end else begin
        pwm_s = pwm_r;
      end
    end

    // Decode from the next count so the strobe lines up with the count == LAST cycle.
    period_end_s = (state_s == RUN) && (count_s == LAST);
  end

  // State, counter, drive and tally registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      count_r      <= {CW{1'b0}};
      pwm_r        <= 1'b0;
      mode_r       <= 1'b0;
      period_end_r <= 1'b0;
      a_cnt_r      <= {TW{1'b0}};
      b_cnt_r      <= {TW{1'b0}};
    end else begin
      state_r      <= state_s;
      count_r      <= count_s;
      pwm_r        <= pwm_s;
      mode_r       <= mode_s;
      period_end_r <= period_end_s;
      a_cnt_r      <= a_cnt_s;
      b_cnt_r      <= b_cnt_s;
    end
  end

`ifdef MULTI_SLOPE_PWM_CAPTURE_EN
  logic [TW-1:0] cap_a_r, cap_b_r;
  logic          cap_valid_r;

  // Snapshot the tally next-state values. A coinciding increment or a
  // start-clear is then included, and both tallies are taken from the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_a_r     <= {TW{1'b0}};
      cap_b_r     <= {TW{1'b0}};
      cap_valid_r <= 1'b0;
    end else begin
      if (capture) begin
        cap_a_r <= a_cnt_s;
        cap_b_r <= b_cnt_s;
      end else begin
        cap_a_r <= cap_a_r;
        cap_b_r <= cap_b_r;
      end
      cap_valid_r <= capture;
    end
  end

  assign cap_a     = cap_a_r;
  assign cap_b     = cap_b_r;
  assign cap_valid = cap_valid_r;
`endif

  assign pwm        = pwm_r;
  assign pwm_mode   = mode_r;
  assign period_end = period_end_r;
  assign running    = (state_r == RUN);
  assign mode_a_cnt = a_cnt_r;
  assign mode_b_cnt = b_cnt_r;

endmodule

// File: tb/tb_multi_slope_pwm.sv
// Directed bench for multi_slope_pwm with default parameters, plus a TW=4
// instance for tally saturation. Expected pulse widths are queued as the
// stimulus is driven. A negedge monitor measures each pwm pulse and pops the
// expected width when the pulse ends.
module tb_multi_slope_pwm;

  logic        clk;
  logic        rst;
  logic        start, stop, enable, reload, mode_req;
  logic        pwm, pwm_mode, period_end, running;
  logic [31:0] mode_a_cnt, mode_b_cnt;
`ifdef MULTI_SLOPE_PWM_CAPTURE_EN
  logic        capture;
  logic [31:0] cap_a, cap_b;
  logic        cap_valid;
`endif

  logic        s_start, s_stop, s_enable, s_reload, s_mode_req;
  logic        s_pwm, s_pwm_mode, s_period_end, s_running;
  logic [3:0]  s_a_cnt, s_b_cnt;
`ifdef MULTI_SLOPE_PWM_CAPTURE_EN
  logic        s_capture;
  logic [3:0]  s_cap_a, s_cap_b;
  logic        s_cap_valid;
`endif

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int width = 0;

  multi_slope_pwm dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .enable(enable),
    .reload(reload), .mode_req(mode_req),
`ifdef MULTI_SLOPE_PWM_CAPTURE_EN
    .capture(capture), .cap_a(cap_a), .cap_b(cap_b), .cap_valid(cap_valid),
`endif
    .pwm(pwm), .pwm_mode(pwm_mode), .period_end(period_end), .running(running),
    .mode_a_cnt(mode_a_cnt), .mode_b_cnt(mode_b_cnt)
  );

  multi_slope_pwm #(.TW(4)) dut_sat (
    .clk(clk), .rst(rst), .start(s_start), .stop(s_stop), .enable(s_enable),
    .reload(s_reload), .mode_req(s_mode_req),
`ifdef MULTI_SLOPE_PWM_CAPTURE_EN
    .capture(s_capture), .cap_a(s_cap_a), .cap_b(s_cap_b), .cap_valid(s_cap_valid),
`endif
    .pwm(s_pwm), .pwm_mode(s_pwm_mode), .period_end(s_period_end), .running(s_running),
    .mode_a_cnt(s_a_cnt), .mode_b_cnt(s_b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse-width monitor: a pulse ends on the first low sample after a high run.
  always @(negedge clk) begin
    if (pwm === 1'b1) begin
      width = width + 1;
    end else if (width != 0) begin
      if (exp_q.size() == 0) begin
        chk("pulse_unexpected", 64'(width), 64'd0);
      end else begin
        chk("pulse_width", 64'(width), 64'(exp_q.pop_front()));
      end
      width = 0;
    end
  end

  initial begin
    rst = 1'b1;
    {start, stop, enable, reload, mode_req} = 5'b00000;
    {s_start, s_stop, s_enable, s_reload, s_mode_req} = 5'b00000;
`ifdef MULTI_SLOPE_PWM_CAPTURE_EN
    capture = 1'b0;
    s_capture = 1'b0;
`endif
    #2 rst = 1'b0;
    tick(2);
    chk("rst_pwm", 64'(pwm), 64'd0);
    chk("rst_mode", 64'(pwm_mode), 64'd0);
    chk("rst_pend", 64'(period_end), 64'd0);
    chk("rst_running", 64'(running), 64'd0);
    chk("rst_a", 64'(mode_a_cnt), 64'd0);
    chk("rst_b", 64'(mode_b_cnt), 64'd0);
    rst = 1'b1;
    tick(2);

    // Mode A, three full periods plus a fourth.
    mode_req = 1'b0; enable = 1'b1; start = 1'b1;
    exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4); exp_q.push_back(4);
    tick(1); start = 1'b0;                       // count 0
    chk("start_running", 64'(running), 64'd1);
    tick(127);                                   // count 127
    chk("a_before_rise", 64'(pwm), 64'd0);
    tick(1);                                     // count 128
    chk("a_rise", 64'(pwm), 64'd1);
    tick(3);                                     // count 131
    chk("a_high_last", 64'(pwm), 64'd1);
    tick(1);                                     // count 132
    chk("a_fall", 64'(pwm), 64'd0);
    chk("a_tally1", 64'(mode_a_cnt), 64'd1);
    tick(126);                                   // count 258
    chk("pend_on", 64'(period_end), 64'd1);
    tick(1);                                     // count 0
    chk("pend_off", 64'(period_end), 64'd0);
    tick(517);                                   // count 258 of period 3
    chk("pend_p3", 64'(period_end), 64'd1);
    chk("a_tally3", 64'(mode_a_cnt), 64'd3);
    chk("b_tally0", 64'(mode_b_cnt), 64'd0);
    tick(1);                                     // count 0 of period 4

    // Mode request arrives mid-period; it takes effect at the wrap.
    tick(50); mode_req = 1'b1;
    chk("mode_hold", 64'(pwm_mode), 64'd0);
    tick(208);                                   // count 258
    chk("mode_hold_end", 64'(pwm_mode), 64'd0);
    chk("a_tally4", 64'(mode_a_cnt), 64'd4);
    exp_q.push_back(255);
    tick(1);                                     // count 0, mode B
    chk("mode_switch", 64'(pwm_mode), 64'd1);
    tick(2);
    chk("b_before_rise", 64'(pwm), 64'd0);
    tick(1);                                     // count 3
    chk("b_rise", 64'(pwm), 64'd1);
    tick(254);                                   // count 257
    chk("b_high_last", 64'(pwm), 64'd1);
    tick(1);                                     // count 258
    chk("b_fall", 64'(pwm), 64'd0);
    chk("b_tally1", 64'(mode_b_cnt), 64'd1);
    tick(1);                                     // count 0

    // Reload at count 200 of a mode-B pulse.
    exp_q.push_back(198);
    tick(200); reload = 1'b1;
    tick(1); reload = 1'b0;                      // count 0
    chk("reload_pwm", 64'(pwm), 64'd0);
    chk("reload_b_hold", 64'(mode_b_cnt), 64'd1);
    exp_q.push_back(98);
    tick(3);                                     // count 3
    chk("reload_restart", 64'(pwm), 64'd1);
    tick(97); enable = 1'b0;                     // count 100
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("enlow_pwm", 64'(pwm), 64'd0);
      chk("enlow_pend", 64'(period_end), 64'd0);
    end
    enable = 1'b1;
    tick(3);                                     // count 3
    chk("enable_restart", 64'(pwm), 64'd1);
    chk("enlow_b_hold", 64'(mode_b_cnt), 64'd1);

    // Start and stop together: start wins and the tallies clear.
    exp_q.push_back(1);
    mode_req = 1'b0; start = 1'b1; stop = 1'b1;
    tick(1); start = 1'b0; stop = 1'b0;
    chk("ss_running", 64'(running), 64'd1);
    chk("ss_pwm", 64'(pwm), 64'd0);
    chk("ss_a", 64'(mode_a_cnt), 64'd0);
    chk("ss_b", 64'(mode_b_cnt), 64'd0);
    chk("ss_mode", 64'(pwm_mode), 64'd0);
    exp_q.push_back(4); exp_q.push_back(2);
    tick(132);
    chk("ss_a1", 64'(mode_a_cnt), 64'd1);
    tick(256);                                   // count 129, mid-pulse
    chk("stop_pre_pwm", 64'(pwm), 64'd1);
    stop = 1'b1;
    tick(1); stop = 1'b0;
    chk("stop_running", 64'(running), 64'd0);
    chk("stop_pwm", 64'(pwm), 64'd0);
    chk("stop_a_hold", 64'(mode_a_cnt), 64'd1);
    reload = 1'b1;
    tick(1); reload = 1'b0;
    chk("idle_reload", 64'(running), 64'd0);
    mode_req = 1'b1;
    tick(1);
    chk("idle_mode_track", 64'(pwm_mode), 64'd1);
    chk("idle_a_hold", 64'(mode_a_cnt), 64'd1);

    // Async reset in the middle of a mode-B pulse.
    exp_q.push_back(255); exp_q.push_back(7);
    start = 1'b1;
    tick(1); start = 1'b0;
    chk("rs_a_clear", 64'(mode_a_cnt), 64'd0);
    tick(259);
    chk("rs_b1", 64'(mode_b_cnt), 64'd1);
    tick(10);                                    // count 10
    chk("rs_pre_pwm", 64'(pwm), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_pwm", 64'(pwm), 64'd0);
    chk("arst_running", 64'(running), 64'd0);
    chk("arst_b", 64'(mode_b_cnt), 64'd0);
    chk("arst_mode", 64'(pwm_mode), 64'd0);
    tick(3);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("post_rst_idle", 64'({running, pwm, period_end}), 64'd0);
    end

    // Saturation on a TW=4 instance.
    s_mode_req = 1'b1; s_enable = 1'b1; s_start = 1'b1;
    tick(1); s_start = 1'b0;
    tick(14 * 259);
    chk("sat_b14", 64'(s_b_cnt), 64'd14);
    tick(259);
    chk("sat_b15", 64'(s_b_cnt), 64'd15);
    tick(5 * 259);
    chk("sat_hold", 64'(s_b_cnt), 64'd15);
    chk("sat_a0", 64'(s_a_cnt), 64'd0);

`ifdef MULTI_SLOPE_PWM_CAPTURE_EN
    // Capture coinciding with the sixth mode-A fall.
    chk("cap_rst_valid", 64'(cap_valid), 64'd0);
    for (int i = 0; i < 6; i++) exp_q.push_back(4);
    mode_req = 1'b0; start = 1'b1;
    tick(1); start = 1'b0;
    tick(1426);                                  // count 131 of period 6
    chk("cap_pre_a", 64'(mode_a_cnt), 64'd5);
    capture = 1'b1;
    tick(1); capture = 1'b0;
    chk("cap_a", 64'(cap_a), 64'd6);
    chk("cap_b", 64'(cap_b), 64'd0);
    chk("cap_valid_on", 64'(cap_valid), 64'd1);
    chk("cap_live_a", 64'(mode_a_cnt), 64'd6);
    tick(1);
    chk("cap_valid_off", 64'(cap_valid), 64'd0);
    chk("cap_a_hold", 64'(cap_a), 64'd6);
    stop = 1'b1;
    tick(1); stop = 1'b0;
`endif

    tick(3);
    chk("pulses_all_seen", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
